// File: rtl/dot_product_reader_pkg.sv
// Shared constants, result-width derivation and FSM state encoding for the dot-product reader.
package dot_product_reader_pkg;

    // Result width needed so that a full-length sum of full-scale products cannot overflow
    function automatic int unsigned acc_width_f(input int unsigned dw, input int unsigned aw);
        return 2 * dw + aw;
    endfunction

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned ADDR_WIDTH = 4;
    localparam int unsigned RAM_DEPTH  = 1 << ADDR_WIDTH;
    localparam int unsigned LEN_WIDTH  = ADDR_WIDTH + 1;
    localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;
    localparam int unsigned ACC_WIDTH  = acc_width_f(DATA_WIDTH, ADDR_WIDTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/dot_product_reader_if.sv
// Control and memory read-port bundle for the dot-product reader.
interface dot_product_reader_if;
    import dot_product_reader_pkg::*;

    logic                  Start;
    logic [LEN_WIDTH-1:0]  Vec_Len;
    logic                  Chip_Select;
    logic                  En_Read;
    logic [ADDR_WIDTH-1:0] Read_Addr;
    logic [DATA_WIDTH-1:0] Read_Data_A;
    logic [DATA_WIDTH-1:0] Read_Data_B;
    logic                  Busy;
    logic                  Done;
    logic [ACC_WIDTH-1:0]  Result;

    // Reader side
    modport slave (
        input  Start, Vec_Len, Read_Data_A, Read_Data_B,
        output Chip_Select, En_Read, Read_Addr, Busy, Done, Result
    );

    // Controller / memory side
    modport master (
        output Start, Vec_Len, Read_Data_A, Read_Data_B,
        input  Chip_Select, En_Read, Read_Addr, Busy, Done, Result
    );

endinterface

// File: rtl/dot_product_mac.sv
// Registered unsigned multiply-accumulate with synchronous clear and enable.
// The next-cycle accumulator value is exported so the caller can capture a
// sum that includes the product being added on the same edge.
module dot_product_mac
    import dot_product_reader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0]  acc_next_c
);

    logic [ACC_WIDTH-1:0]  acc_q;
    logic [ACC_WIDTH-1:0]  acc_d;
    logic [PROD_WIDTH-1:0] prod_c;

    // Product and next accumulator value; clear wins over enable
    always_comb begin
        prod_c = PROD_WIDTH'(a) * PROD_WIDTH'(b);
        acc_d  = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + ACC_WIDTH'(prod_c);
        end
    end

    assign acc_next_c = acc_d;

    // Accumulator register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/dot_product_reader.sv
// Read-side sequencer: issues addresses 0..N-1 to both vector memories,
// delays the read enable to line up with registered read data, and
// publishes the accumulated dot product with a one-cycle Done pulse.
module dot_product_reader
    import dot_product_reader_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    dot_product_reader_if.slave bus
);

    logic [1:0]            state_q,  state_d;
    logic [ADDR_WIDTH-1:0] cnt_q,    cnt_d;
    logic [LEN_WIDTH-1:0]  n_q,      n_d;
    logic                  cs_q,     cs_d;
    logic                  en_q,     en_d;
    logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
    logic                  busy_q,   busy_d;
    logic                  done_q,   done_d;
    logic [ACC_WIDTH-1:0]  result_q, result_d;
    logic                  acc_en_q, acc_en_d;
    logic [LEN_WIDTH-1:0]  vec_len_clamp_c;
    logic                  clr_c;
    logic [ACC_WIDTH-1:0]  acc_next_c;

    // Next state, counter and next-cycle output values
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        n_d      = n_q;
        clr_c    = 1'b0;
        vec_len_clamp_c = (bus.Vec_Len > LEN_WIDTH'(RAM_DEPTH)) ? LEN_WIDTH'(RAM_DEPTH)
                                                                : bus.Vec_Len;
        case (state_q)
            ST_IDLE: begin
                if (bus.Start) begin
                    clr_c   = 1'b1;
                    n_d     = vec_len_clamp_c;
                    cnt_d   = '0;
                    state_d = (vec_len_clamp_c == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if ({1'b0, cnt_q} == (n_q - LEN_WIDTH'(1))) begin
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        en_d     = (state_d == ST_ISSUE);
        cs_d     = (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
        addr_d   = en_d ? cnt_d : '0;
        busy_d   = cs_d;
        done_d   = (state_d == ST_DONE);
        result_d = done_d ? acc_next_c : result_q;
        acc_en_d = en_q;
    end

    // State, counter and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            n_q      <= '0;
            cs_q     <= 1'b0;
            en_q     <= 1'b0;
            addr_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            acc_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            n_q      <= n_d;
            cs_q     <= cs_d;
            en_q     <= en_d;
            addr_q   <= addr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            acc_en_q <= acc_en_d;
        end
    end

    dot_product_mac u_mac (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr_c),
        .en         (acc_en_q),
        .a          (bus.Read_Data_A),
        .b          (bus.Read_Data_B),
        .acc_next_c (acc_next_c)
    );

    assign bus.Chip_Select = cs_q;
    assign bus.En_Read     = en_q;
    assign bus.Read_Addr   = addr_q;
    assign bus.Busy        = busy_q;
    assign bus.Done        = done_q;
    assign bus.Result      = result_q;

endmodule

// File: tb/tb_dot_product_reader.sv
// Bench for dot_product_reader: behavioural memories plus a timing model
// derived from the cycle-level operation description.
module tb_dot_product_reader;
    import dot_product_reader_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   done_cnt;

    logic [DATA_WIDTH-1:0] mem_a [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] mem_b [RAM_DEPTH];

    dot_product_reader_if bus ();

    dot_product_reader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memories with one-cycle registered read, returning 0 when not enabled
    always @(posedge clk) begin
        if (bus.Chip_Select && bus.En_Read) begin
            bus.Read_Data_A <= mem_a[bus.Read_Addr];
            bus.Read_Data_B <= mem_b[bus.Read_Addr];
        end else begin
            bus.Read_Data_A <= '0;
            bus.Read_Data_B <= '0;
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    bit     m_active;
    int     m_t;
    int     m_n;
    longint m_sum;
    longint m_result;

    // Per-cycle comparison against the model, then advance the model
    always @(negedge clk) begin
        bit e_cs, e_en, e_busy, e_done;
        int e_addr;
        int t_done;
        e_cs = 0; e_en = 0; e_busy = 0; e_done = 0; e_addr = 0;
        if (rst) begin
            m_active = 0;
            m_result = 0;
        end else if (m_active) begin
            if (m_n == 0) begin
                e_done = (m_t == 1);
            end else if (m_t <= m_n) begin
                e_cs = 1; e_en = 1; e_busy = 1; e_addr = m_t - 1;
            end else if (m_t == m_n + 1) begin
                e_cs = 1; e_busy = 1;
            end else begin
                e_done = 1;
            end
            if (e_done) m_result = m_sum;
        end
        if (bus.Done) done_cnt++;

        check("chip_select", longint'(bus.Chip_Select), longint'(e_cs));
        check("en_read",     longint'(bus.En_Read),     longint'(e_en));
        check("busy",        longint'(bus.Busy),        longint'(e_busy));
        check("done",        longint'(bus.Done),        longint'(e_done));
        check("result",      longint'(bus.Result),      m_result);
        if (e_en || rst) check("read_addr", longint'(bus.Read_Addr), longint'(e_addr));

        t_done = (m_n == 0) ? 1 : m_n + 2;
        if (rst) begin
            m_active = 0;
        end else if (m_active) begin
            if (m_t == t_done) m_active = 0;
            else m_t++;
        end else if (bus.Start) begin
            m_active = 1;
            m_t      = 1;
            m_n      = (int'(bus.Vec_Len) > int'(RAM_DEPTH)) ? int'(RAM_DEPTH) : int'(bus.Vec_Len);
            m_sum    = 0;
            for (int i = 0; i < m_n; i++) m_sum += longint'(mem_a[i]) * longint'(mem_b[i]);
        end
    end

    // Single operation from IDLE with hand-computed expected result and Done latency
    task automatic run_op(input int n, input longint exp_res, input int exp_lat);
        int lat;
        lat = 0;
        bus.Start   = 1'b1;
        bus.Vec_Len = LEN_WIDTH'(n);
        @(posedge clk); #1;
        bus.Start = 1'b0;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            @(negedge clk);
            if (bus.Done) lat = i;
        end
        @(posedge clk); #1;
        check("done_latency", longint'(lat), longint'(exp_lat));
        check("final_result", longint'(bus.Result), exp_res);
    endtask

    task automatic fill_ramp;
        for (int i = 0; i < int'(RAM_DEPTH); i++) begin
            mem_a[i] = DATA_WIDTH'(i + 1);
            mem_b[i] = DATA_WIDTH'(2);
        end
    endtask

    initial begin
        int nc;
        int d0;
        checks = 0; errors = 0; done_cnt = 0;
        m_active = 0; m_t = 0; m_n = 0; m_sum = 0; m_result = 0;
        rst = 1'b1;
        bus.Start = 1'b0;
        bus.Vec_Len = '0;
        fill_ramp();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        run_op(4, 20, 6);

        for (int i = 0; i < int'(RAM_DEPTH); i++) begin
            mem_a[i] = 8'd255;
            mem_b[i] = 8'd255;
        end
        run_op(16, 1040400, 18);
        run_op(20, 1040400, 18);
        run_op(0, 0, 1);

        // Start held high across two N=3 operations
        fill_ramp();
        d0 = done_cnt;
        bus.Start   = 1'b1;
        bus.Vec_Len = LEN_WIDTH'(3);
        repeat (12) @(posedge clk);
        #1 bus.Start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("held_start_done_count", longint'(done_cnt - d0), 2);
        check("held_start_result", longint'(bus.Result), 12);

        // Reset in the middle of an N=8 operation
        bus.Start   = 1'b1;
        bus.Vec_Len = LEN_WIDTH'(8);
        @(posedge clk); #1;
        bus.Start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_busy",   longint'(bus.Busy), 0);
        check("rst_en",     longint'(bus.En_Read), 0);
        check("rst_cs",     longint'(bus.Chip_Select), 0);
        check("rst_result", longint'(bus.Result), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        run_op(2, 6, 4);

        // Randomized operations with ignored Start activity while busy
        for (int op = 0; op < 40; op++) begin
            for (int i = 0; i < int'(RAM_DEPTH); i++) begin
                mem_a[i] = DATA_WIDTH'($urandom_range(0, 255));
                mem_b[i] = DATA_WIDTH'($urandom_range(0, 255));
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            nc = $urandom_range(0, 20);
            bus.Start   = 1'b1;
            bus.Vec_Len = LEN_WIDTH'(nc);
            if (nc > int'(RAM_DEPTH)) nc = int'(RAM_DEPTH);
            for (int t = 1; t <= nc + 1; t++) begin
                @(posedge clk); #1;
                bus.Start   = 1'($urandom_range(0, 1));
                bus.Vec_Len = LEN_WIDTH'($urandom_range(0, 31));
            end
            @(posedge clk); #1;
            bus.Start = 1'b0;
            @(posedge clk); #1;
        end

        repeat (2) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dot_product_reader.md
# dot_product_reader

Read-side sequencer and accumulator for the dot-product datapath. On a start request it streams addresses 0..N-1 to two vector memories (A and B) sharing one read address, compensates for their one-cycle registered read latency, and accumulates the unsigned products into a single result. It sits between the control logic that loads the vectors and the two memories' read ports, driving their Chip_Select, En_Read and Read_Addr.

## Interface
- data_width, 8, width of each vector element and of the memory read data
- addr_width, 4, memory address width
- Ram_Depth, 1 << addr_width, maximum vector length
- acc_width, 2*data_width + addr_width, result width; overflow is impossible at full length
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, asynchronous, active-high
- Start  in  1  request a dot product; sampled only in IDLE
- Vec_Len  in  addr_width+1  element count N, captured with Start; valid range 0..Ram_Depth
- Chip_Select  out  1  memory chip select, shared by A and B
- En_Read  out  1  memory read enable, shared by A and B
- Read_Addr  out  addr_width  memory read address, shared by A and B
- Read_Data_A  in  data_width  registered read data from memory A
- Read_Data_B  in  data_width  registered read data from memory B
- Busy  out  1  operation in progress
- Done  out  1  one-cycle pulse: Result is updated
- Result  out  acc_width  last completed dot product, held until the next Done

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: Start=1 captures N = min(Vec_Len, Ram_Depth), clears the accumulator and address counter. N=0 goes to DONE. N>0 goes to ISSUE.
- ISSUE:
  - Chip_Select=1, En_Read=1, Read_Addr = counter.
  - The counter increments each cycle.
  - After the cycle that issues address N-1, go to DRAIN.
- DRAIN: one cycle, Chip_Select=1, En_Read=0. It absorbs the last in-flight read. Then go to DONE.
- Accumulate enable is a one-cycle-delayed copy of the ISSUE-state read enable. When it is set: acc <= acc + Read_Data_A * Read_Data_B.
- Arithmetic:
  - Unsigned throughout.
  - The product is 2*data_width bits, zero-extended to acc_width.
  - No saturation is needed.
- DONE: Result <= acc, Done=1 for exactly one cycle, then IDLE.
- Start outside IDLE (ISSUE, DRAIN or DONE) is ignored; it is not queued.
- Vec_Len > Ram_Depth is clamped to Ram_Depth.
- No address wrap occurs. The counter stops at N-1.
- Reset, at any time including mid-operation:
  - State goes to IDLE, and the accumulator and counter clear.
  - Busy=0, Done=0, Chip_Select=0, En_Read=0, Read_Addr=0, Result=0.
  - A partial sum is discarded.

## Timing
- Start accepted at cycle 0 (IDLE, Start=1).
- N>0:
  - ISSUE cycles 1..N, with Read_Addr=k in cycle k+1.
  - Read data for address k is valid in cycle k+2 and is accumulated at the end of that cycle.
  - DRAIN is cycle N+1.
  - Done=1 and the new Result appear in cycle N+2.
- N=0: DONE in cycle 1, Done=1, Result=0, no memory access.
- Busy=1 in cycles 1..N+1 (N>0); Busy=0 in DONE and IDLE.
- Earliest next Start: cycle N+3 (IDLE). Back-to-back throughput is N+3 cycles per vector.
- The memories return 0 when not enabled; the design does not rely on this.

## Structure
- Shared package holds:
  - the state encoding (IDLE/ISSUE/DRAIN/DONE)
  - an acc_width derivation constant/function, (2*data_width + addr_width), reused by downstream consumers of Result
- One sub-module, dot_product_mac:
  - contains the registered multiply-accumulate with synchronous clear and enable, and asynchronous reset
  - the FSM, counter and read-enable delay stay in the top.

## Test plan
- Preload both memories with values:
  - A[i]=i+1 and B[i]=2 for i=0..3; Start with Vec_Len=4 -> Done in cycle 6, Result=20, Busy high in cycles 1..5.
  - A=B=255 in all 16 words; Vec_Len=16 -> Result=1040400 (16*65025), no overflow, Done in cycle 18.
- Vec_Len=0 -> Done in cycle 1, Result=0, En_Read never asserted. Vec_Len=20 behaves exactly as Vec_Len=16.
- Start held high continuously over two operations of N=3 -> second accepted only in IDLE (cycle 6); Start pulses in Busy/DONE are ignored. Each Result is correct.
- Assert rst in cycle 3 of an N=8 operation -> all outputs 0 immediately. A following Start with N=2 gives the correct Result with no residue from the aborted sum.
- Check Read_Addr sequence 0..N-1 against En_Read every cycle. Check that Done is exactly one cycle wide and that Result stays stable between Done pulses.
